mac_tx_framer: RTL and testbench
================================

Name: mac_tx_framer

Overview:
- Transmit-side framer between a user AXI-Stream byte source (e.g. the tx side of eth_fifo) and the mac_rgmii transmit interface (mac_tx_data/valid/sof/eof).
- Turns user frames (DA through payload, no preamble, no FCS) into MAC-ready frames:
  - pads short frames to the 60-byte minimum;
  - appends the IEEE 802.3 CRC32 FCS;
  - enforces the inter-frame gap.
- It is the transmit counterpart of the mac_rgmii receive path (mac_rx_data/valid/sof/eof plus ok/bd/er). Preamble and SFD are added by mac_rgmii, not by this block.

Parameters:
- PAD_EN, 1: pad frames shorter than MIN_LEN with 0x00 before the FCS (0 = no padding).
- MIN_LEN, 60: minimum byte count before the FCS.
- MAX_LEN, 1514: maximum byte count before the FCS. Longer frames are aborted.
- IFG_LEN, 12: idle cycles forced between the eof of one frame and the sof of the next (minimum 1).

Ports:
- clk  in  1  byte clock (mac_gtx_clk, 125 MHz at 1G)
- rst  in  1  synchronous, active-high reset
- s_tdata  in  8  user frame byte
- s_tvalid  in  1  user byte valid
- s_tlast  in  1  last byte of the user frame
- s_tready  out  1  byte accepted when s_tvalid & s_tready
- mac_tx_data  out  8  byte to the MAC
- mac_tx_valid  out  1  byte valid; continuous from sof to eof
- mac_tx_sof  out  1  first byte (DA[0])
- mac_tx_eof  out  1  last FCS byte
- frame_cnt  out  16  good frames sent; wraps
- err_cnt  out  16  frames aborted (underrun or oversize); wraps
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC = 0xFFFFFFFF, counters 0, IFG counter 0. Reset mid-frame returns to IDLE on the next edge; the partial frame is simply cut (no eof). The first frame after reset needs no IFG.
- Output registering:
  - all mac_tx_* outputs are registered;
  - an accepted input byte appears on mac_tx_data exactly 1 cycle after acceptance;
  - s_tready is combinational from state.
- State IDLE:
  - s_tready = 1.
  - On s_tvalid, accept the byte, next cycle output it with sof = 1, and go to DATA, or to PAD/FCS if s_tlast is set with a 1-byte frame.
  - The length counter (11 bits) counts output bytes.
- State DATA:
  - s_tready = 1; each accepted byte is output and folded into the CRC.
  - Accepted byte with s_tlast = 1: go to PAD if PAD_EN and length < MIN_LEN, else go to FCS.
  - s_tvalid = 0 in DATA is an underrun:
    - emit a 4-byte FCS equal to the bitwise inverse of the correct FCS, with eof on the last byte;
    - err_cnt += 1;
    - go to DRAIN.
  - Accepting byte number MAX_LEN+1 (an oversize frame) is handled the same as an underrun: the overflowing byte is not output.
- State PAD: s_tready = 0. Output 0x00 (folded into the CRC) until length = MIN_LEN, then go to FCS.
- State FCS:
  - s_tready = 0.
  - FCS = ~CRC, transmitted LSB byte first (bits 7:0, 15:8, 23:16, 31:24).
  - eof = 1 on the 4th byte; frame_cnt += 1 on that cycle; then go to IFG.
- CRC: reflected Ethernet CRC32, polynomial 0x04C11DB7 (reflected 0xEDB88320), init 0xFFFFFFFF, one byte per cycle, covers DA through the last pad byte.
- State DRAIN:
  - s_tready = 1; discard bytes until an accepted byte has s_tlast = 1;
  - no mac_tx_valid while in DRAIN;
  - then go to IFG, or go directly to IFG if the aborting byte itself carried tlast.
- State IFG: s_tready = 0, mac_tx_valid = 0 for IFG_LEN cycles after the eof cycle, then go to IDLE.
- mac_tx_valid must never drop between sof and eof. sof and eof are never asserted on the same cycle, because the minimum output is 1 data byte plus 4 FCS bytes.

Test Plan:
- PAD_EN=0, send ASCII "123456789" (9 bytes, tlast on '9') -> 13 output bytes: 31..39 then FCS 26 39 F4 CB; sof on 0x31, eof on 0xCB; frame_cnt = 1.
- PAD_EN=1, 1-byte frame 0xAA -> 0xAA, 59 bytes of 0x00, 4 FCS bytes; 64 valid cycles contiguous; FCS matches a reference-model CRC.
- Two back-to-back 64-byte frames with s_tvalid held high -> exactly IFG_LEN=12 idle cycles between eof and the next sof; s_tready low during PAD/FCS/IFG.
- Underrun: drop s_tvalid after 20 bytes for 3 cycles, then finish the frame -> 20 data bytes + inverted FCS with eof; err_cnt = 1; remaining input discarded through tlast; next frame is sent normally.
- Oversize: 1600-byte frame -> 1514 data bytes + inverted FCS; err_cnt increments; drain to tlast.
- Assert rst in the middle of DATA -> all outputs 0 on the next edge; the following frame starts with sof and no IFG wait.

Source files
------------

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: turns user AXI-Stream frames (DA..payload) into MAC-ready
// frames for mac_rgmii. It pads short frames, appends the CRC32 FCS and
// enforces the inter-frame gap. An underrun or an oversize frame is cut
// short and closed with an inverted FCS so that the receiver drops it.
module mac_tx_framer #(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_DRAIN,
        S_IFG
    } state_t;

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LOAD = 16'(IFG_LEN - 1);

    state_t      state;
    logic [10:0] len;        // bytes already sent in the current frame
    logic [31:0] crc;        // running CRC register, not yet inverted
    logic [1:0]  fcs_idx;    // next FCS byte to send, LSB byte first
    logic        corrupt;    // frame aborted: send the inverse of the good FCS
    logic        skip_drain; // aborting byte already carried tlast
    logic [15:0] ifg_cnt;
    logic [10:0] len_inc;

    assign len_inc  = len + 11'd1;
    assign s_tready = (state == S_IDLE) || (state == S_DATA) || (state == S_DRAIN);
    assign busy     = (state != S_IDLE);

    // Reflected Ethernet CRC32, one byte per call
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // FCS byte selection; an aborted frame sends the raw register, which is
    // the bitwise inverse of the correct FCS
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx,
                                            input logic inv);
        logic [31:0] f;
        logic [7:0]  b;
        f = inv ? c : ~c;
        unique case (idx)
            2'd0: b = f[7:0];
            2'd1: b = f[15:8];
            2'd2: b = f[23:16];
            default: b = f[31:24];
        endcase
        return b;
    endfunction

    // Framer state machine with registered MAC-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len          <= '0;
            crc          <= 32'hFFFFFFFF;
            fcs_idx      <= '0;
            corrupt      <= 1'b0;
            skip_drain   <= 1'b0;
            ifg_cnt      <= '0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
        end else begin
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (s_tvalid) begin
                        mac_tx_data  <= s_tdata;
                        mac_tx_valid <= 1'b1;
                        mac_tx_sof   <= 1'b1;
                        crc          <= crc_byte(32'hFFFFFFFF, s_tdata);
                        len          <= 11'd1;
                        fcs_idx      <= 2'd0;
                        corrupt      <= 1'b0;
                        skip_drain   <= 1'b0;
                        if (!s_tlast) begin
                            state <= S_DATA;
                        end else if (PAD_EN && (MIN_L > 11'd1)) begin
                            state <= S_PAD;
                        end else begin
                            state <= S_FCS;
                        end
                    end
                end
                S_DATA: begin
                    if (!s_tvalid || (len == MAX_L)) begin
                        // Abort: the first corrupted FCS byte goes out now so
                        // that valid stays continuous up to eof
                        mac_tx_data  <= fcs_byte(crc, 2'd0, 1'b1);
                        mac_tx_valid <= 1'b1;
                        fcs_idx      <= 2'd1;
                        corrupt      <= 1'b1;
                        skip_drain   <= s_tvalid && s_tlast;
                        err_cnt      <= err_cnt + 16'd1;
                        state        <= S_FCS;
                    end else begin
                        mac_tx_data  <= s_tdata;
                        mac_tx_valid <= 1'b1;
                        crc          <= crc_byte(crc, s_tdata);
                        len          <= len_inc;
                        if (s_tlast) begin
                            state <= (PAD_EN && (len_inc < MIN_L)) ? S_PAD : S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    mac_tx_valid <= 1'b1;
                    crc          <= crc_byte(crc, 8'h00);
                    len          <= len_inc;
                    if (len_inc >= MIN_L) begin
                        state <= S_FCS;
                    end
                end
                S_FCS: begin
                    mac_tx_data  <= fcs_byte(crc, fcs_idx, corrupt);
                    mac_tx_valid <= 1'b1;
                    fcs_idx      <= fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        mac_tx_eof <= 1'b1;
                        ifg_cnt    <= IFG_LOAD;
                        if (!corrupt) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        state <= (corrupt && !skip_drain) ? S_DRAIN : S_IFG;
                    end
                end
                S_DRAIN: begin
                    if (s_tvalid && s_tlast) begin
                        ifg_cnt <= IFG_LOAD;
                        state   <= S_IFG;
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == 16'd0) begin
                        state <= S_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed testbench for mac_tx_framer. dut0 runs without padding (CRC check
// vector), dut1 with default parameters for all other scenarios.
module tb_mac_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;

    logic        tready0, tx_valid0, tx_sof0, tx_eof0, busy0;
    logic [7:0]  tx_data0;
    logic [15:0] frame_cnt0, err_cnt0;
    logic        tready1, tx_valid1, tx_sof1, tx_eof1, busy1;
    logic [7:0]  tx_data1;
    logic [15:0] frame_cnt1, err_cnt1;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       rdy;
        int         cyc;
    } ob_t;

    ob_t q0[$];
    ob_t q1[$];
    int  cyc      = 0;
    int  idle_rdy = 0;
    int  errors   = 0;
    int  checks   = 0;

    always #4 clk = ~clk;

    mac_tx_framer #(.PAD_EN(1'b0), .MIN_LEN(60), .MAX_LEN(1514), .IFG_LEN(12)) dut0 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(tready0), .mac_tx_data(tx_data0), .mac_tx_valid(tx_valid0),
        .mac_tx_sof(tx_sof0), .mac_tx_eof(tx_eof0), .frame_cnt(frame_cnt0),
        .err_cnt(err_cnt0), .busy(busy0)
    );

    mac_tx_framer #(.PAD_EN(1'b1), .MIN_LEN(60), .MAX_LEN(1514), .IFG_LEN(12)) dut1 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(tready1), .mac_tx_data(tx_data1), .mac_tx_valid(tx_valid1),
        .mac_tx_sof(tx_sof1), .mac_tx_eof(tx_eof1), .frame_cnt(frame_cnt1),
        .err_cnt(err_cnt1), .busy(busy1)
    );

    // Cycle counter and output monitors, sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_valid0) q0.push_back('{tx_data0, tx_sof0, tx_eof0, tready0, cyc});
        if (tx_valid1) q1.push_back('{tx_data1, tx_sof1, tx_eof1, tready1, cyc});
        if (!tx_valid1 && busy1 && tready1) idle_rdy++;
    end

    function automatic logic [7:0] pat(input int base, input int step, input int i);
        return 8'(base + step * i);
    endfunction

    // Bit-serial reference CRC over n pattern bytes zero-padded to pad_to bytes;
    // returns the register before the final inversion
    function automatic logic [31:0] ref_crc(input int n, input int base, input int step,
                                            input int pad_to);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        int          total;
        c = 32'hFFFFFFFF;
        total = (pad_to > n) ? pad_to : n;
        for (int i = 0; i < total; i++) begin
            b = (i < n) ? pat(base, step, i) : 8'h00;
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic int count_sof(input ob_t q[$]);
        int n = 0;
        foreach (q[i]) if (q[i].sof) n++;
        return n;
    endfunction

    function automatic int count_eof(input ob_t q[$]);
        int n = 0;
        foreach (q[i]) if (q[i].eof) n++;
        return n;
    endfunction

    // Drive n bytes with handshake; optional s_tvalid gap before byte gap_at.
    // Leaves s_tvalid/s_tlast as they were for the last byte.
    task automatic send(input int n, input int base, input int step, input int gap_at,
                        input int gap_len, input bit use0);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = pat(base, step, i);
            s_tlast  = (i == n - 1);
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 5000) begin
                @(negedge clk);
                acc = use0 ? tready0 : tready1;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                $display("FAIL send_handshake: byte %0d ready=0 required 1", i);
                errors++;
                checks++;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 6000; t++) begin
            @(posedge clk);
            #1;
            if (!busy1) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
        end
        $display("FAIL %s_timeout: busy=%0b required 0", name, busy1);
        errors++;
        checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_valid1, tx_sof1, tx_eof1, tx_data1, busy1} !== 12'h0) begin
            $display("FAIL reset_out1: got %h required 0", {tx_valid1, tx_sof1, tx_eof1, tx_data1, busy1});
            errors++;
        end
        checks++;
        if ({frame_cnt1, err_cnt1} !== 32'h0) begin
            $display("FAIL reset_cnt1: got %h required 0", {frame_cnt1, err_cnt1});
            errors++;
        end
        checks++;
        if ({tx_valid0, tx_sof0, tx_eof0, tx_data0, busy0, frame_cnt0, err_cnt0} !== 44'h0) begin
            $display("FAIL reset_dut0: got %h required 0", {tx_valid0, tx_sof0, tx_eof0, tx_data0, busy0, frame_cnt0, err_cnt0});
            errors++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (tready1 !== 1'b1) begin
            $display("FAIL idle_ready: got %b required 1", tready1);
            errors++;
        end
    endtask

    task automatic test_crc_nopad();
        logic [7:0] exp [13];
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        q0.delete(); q1.delete();
        send(9, 8'h31, 1, -1, 0, 1'b1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("crc_nopad");
        checks++;
        if (q0.size() !== 13) begin
            $display("FAIL nopad_len: got %0d required 13", q0.size());
            errors++;
        end else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (q0[i].d !== exp[i]) begin
                    $display("FAIL nopad_byte%0d: got %h required %h", i, q0[i].d, exp[i]);
                    errors++;
                end
            end
            checks++;
            if (!(q0[0].sof && q0[12].eof && count_sof(q0) == 1 && count_eof(q0) == 1)) begin
                $display("FAIL nopad_flags: sof=%0d eof=%0d required 1 1 at ends", count_sof(q0), count_eof(q0));
                errors++;
            end
            checks++;
            if (q0[12].cyc - q0[0].cyc !== 12) begin
                $display("FAIL nopad_contig: got span %0d required 12", q0[12].cyc - q0[0].cyc);
                errors++;
            end
        end
        checks++;
        if (frame_cnt0 !== 16'd1) begin
            $display("FAIL nopad_frame_cnt: got %0d required 1", frame_cnt0);
            errors++;
        end
    endtask

    task automatic test_pad();
        logic [31:0] fcs;
        int nz;
        q1.delete();
        send(1, 8'hAA, 0, -1, 0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("pad");
        fcs = ~ref_crc(1, 8'hAA, 0, 60);
        checks++;
        if (q1.size() !== 64) begin
            $display("FAIL pad_len: got %0d required 64", q1.size());
            errors++;
        end else begin
            checks++;
            if (q1[0].d !== 8'hAA || !q1[0].sof) begin
                $display("FAIL pad_first: got %h sof=%b required aa sof=1", q1[0].d, q1[0].sof);
                errors++;
            end
            nz = 0;
            for (int i = 1; i < 60; i++) if (q1[i].d !== 8'h00) nz++;
            checks++;
            if (nz !== 0) begin
                $display("FAIL pad_zeros: got %0d nonzero pad bytes required 0", nz);
                errors++;
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q1[60 + k].d !== 8'(fcs >> (8 * k))) begin
                    $display("FAIL pad_fcs%0d: got %h required %h", k, q1[60 + k].d, 8'(fcs >> (8 * k)));
                    errors++;
                end
            end
            checks++;
            if (!q1[63].eof || count_eof(q1) != 1 || q1[63].cyc - q1[0].cyc != 63) begin
                $display("FAIL pad_eof_contig: eof=%b span=%0d required 1 63", q1[63].eof, q1[63].cyc - q1[0].cyc);
                errors++;
            end
        end
        checks++;
        if (frame_cnt1 !== 16'd2) begin
            $display("FAIL pad_frame_cnt: got %0d required 2", frame_cnt1);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fa, fb;
        int bad;
        q1.delete();
        idle_rdy = 0;
        send(64, 8'h10, 5, -1, 0, 1'b0);
        send(64, 8'h80, 11, -1, 0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("b2b");
        fa = ~ref_crc(64, 8'h10, 5, 0);
        fb = ~ref_crc(64, 8'h80, 11, 0);
        checks++;
        if (q1.size() !== 136) begin
            $display("FAIL b2b_len: got %0d required 136", q1.size());
            errors++;
        end else begin
            checks++;
            if (!(q1[0].sof && q1[67].eof && q1[68].sof && q1[135].eof)) begin
                $display("FAIL b2b_flags: sof/eof at 0,67,68,135 got %b%b%b%b required 1111", q1[0].sof, q1[67].eof, q1[68].sof, q1[135].eof);
                errors++;
            end
            checks++;
            if (q1[68].cyc - q1[67].cyc !== 13) begin
                $display("FAIL b2b_ifg: got %0d idle cycles required 12", q1[68].cyc - q1[67].cyc - 1);
                errors++;
            end
            bad = 0;
            for (int i = 0; i < 64; i++) if (q1[68 + i].d !== pat(8'h80, 11, i)) bad++;
            checks++;
            if (bad !== 0) begin
                $display("FAIL b2b_data: got %0d wrong bytes required 0", bad);
                errors++;
            end
            bad = 0;
            for (int k = 0; k < 4; k++) begin
                if (q1[64 + k].d !== 8'(fa >> (8 * k))) bad++;
                if (q1[132 + k].d !== 8'(fb >> (8 * k))) bad++;
            end
            checks++;
            if (bad !== 0) begin
                $display("FAIL b2b_fcs: got %0d wrong FCS bytes required 0", bad);
                errors++;
            end
            bad = 0;
            for (int k = 64; k < 68; k++) if (q1[k].rdy !== 1'b0) bad++;
            checks++;
            if (bad !== 0 || idle_rdy !== 0) begin
                $display("FAIL b2b_ready_low: got %0d/%0d ready cycles in FCS/IFG required 0", bad, idle_rdy);
                errors++;
            end
        end
        checks++;
        if (frame_cnt1 !== 16'd4) begin
            $display("FAIL b2b_frame_cnt: got %0d required 4", frame_cnt1);
            errors++;
        end
    endtask

    task automatic test_underrun();
        logic [31:0] raw, good;
        int bad;
        q1.delete();
        send(30, 8'h20, 3, 20, 3, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("underrun");
        raw = ref_crc(20, 8'h20, 3, 0);
        checks++;
        if (q1.size() !== 24) begin
            $display("FAIL underrun_len: got %0d required 24", q1.size());
            errors++;
        end else begin
            bad = 0;
            for (int i = 0; i < 20; i++) if (q1[i].d !== pat(8'h20, 3, i)) bad++;
            for (int k = 0; k < 4; k++) if (q1[20 + k].d !== 8'(raw >> (8 * k))) bad++;
            checks++;
            if (bad !== 0) begin
                $display("FAIL underrun_bytes: got %0d wrong bytes required 0", bad);
                errors++;
            end
            checks++;
            if (!(q1[0].sof && q1[23].eof && count_eof(q1) == 1 && q1[23].cyc - q1[0].cyc == 23)) begin
                $display("FAIL underrun_flags: eof=%b span=%0d required 1 23", q1[23].eof, q1[23].cyc - q1[0].cyc);
                errors++;
            end
        end
        checks++;
        if (err_cnt1 !== 16'd1 || frame_cnt1 !== 16'd4) begin
            $display("FAIL underrun_cnt: got err=%0d frames=%0d required 1 4", err_cnt1, frame_cnt1);
            errors++;
        end
        q1.delete();
        send(64, 8'h33, 1, -1, 0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("after_underrun");
        good = ~ref_crc(64, 8'h33, 1, 0);
        checks++;
        if (q1.size() !== 68 || q1[67].d !== good[31:24] || q1[64].d !== good[7:0] || !q1[0].sof) begin
            $display("FAIL after_underrun_frame: got len=%0d last=%h required 68 %h", q1.size(), q1[67].d, good[31:24]);
            errors++;
        end
        checks++;
        if (frame_cnt1 !== 16'd5) begin
            $display("FAIL after_underrun_cnt: got %0d required 5", frame_cnt1);
            errors++;
        end
    endtask

    task automatic test_oversize();
        logic [31:0] raw;
        int bad;
        q1.delete();
        send(1600, 8'h01, 1, -1, 0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("oversize");
        raw = ref_crc(1514, 8'h01, 1, 0);
        checks++;
        if (q1.size() !== 1518) begin
            $display("FAIL oversize_len: got %0d required 1518", q1.size());
            errors++;
        end else begin
            bad = 0;
            for (int i = 0; i < 1514; i++) if (q1[i].d !== pat(8'h01, 1, i)) bad++;
            checks++;
            if (bad !== 0) begin
                $display("FAIL oversize_data: got %0d wrong bytes required 0", bad);
                errors++;
            end
            bad = 0;
            for (int k = 0; k < 4; k++) if (q1[1514 + k].d !== 8'(raw >> (8 * k))) bad++;
            checks++;
            if (bad !== 0) begin
                $display("FAIL oversize_fcs: got %0d wrong FCS bytes required 0", bad);
                errors++;
            end
            checks++;
            if (!(q1[1517].eof && count_eof(q1) == 1 && count_sof(q1) == 1 && q1[1517].cyc - q1[0].cyc == 1517)) begin
                $display("FAIL oversize_flags: eof=%b span=%0d required 1 1517", q1[1517].eof, q1[1517].cyc - q1[0].cyc);
                errors++;
            end
        end
        checks++;
        if (err_cnt1 !== 16'd2 || frame_cnt1 !== 16'd5) begin
            $display("FAIL oversize_cnt: got err=%0d frames=%0d required 2 5", err_cnt1, frame_cnt1);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] good;
        int c0;
        q1.delete();
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1; s_tdata = pat(8'h40, 1, i); s_tlast = 1'b0;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tx_valid1, tx_sof1, tx_eof1, tx_data1, busy1, frame_cnt1, err_cnt1} !== 44'h0) begin
            $display("FAIL midreset_out: got %h required 0", {tx_valid1, tx_sof1, tx_eof1, tx_data1, busy1, frame_cnt1, err_cnt1});
            errors++;
        end
        checks++;
        if (q1.size() !== 10 || count_eof(q1) !== 0) begin
            $display("FAIL midreset_cut: got len=%0d eofs=%0d required 10 0", q1.size(), count_eof(q1));
            errors++;
        end
        rst = 1'b0; s_tvalid = 1'b0;
        c0 = cyc;
        q1.delete();
        send(64, 8'h55, 7, -1, 0, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        wait_idle("midreset");
        good = ~ref_crc(64, 8'h55, 7, 0);
        checks++;
        if (q1.size() !== 68 || !q1[0].sof || q1[0].cyc !== c0 + 1) begin
            $display("FAIL midreset_sof: got len=%0d sof_cyc=%0d required 68 %0d", q1.size(), q1[0].cyc, c0 + 1);
            errors++;
        end
        checks++;
        if (q1[64].d !== good[7:0] || q1[67].d !== good[31:24] || !q1[67].eof) begin
            $display("FAIL midreset_fcs: got %h..%h required %h..%h", q1[64].d, q1[67].d, good[7:0], good[31:24]);
            errors++;
        end
        checks++;
        if (frame_cnt1 !== 16'd1) begin
            $display("FAIL midreset_cnt: got %0d required 1", frame_cnt1);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_crc_nopad();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
